// File: rtl/addr_decoder_param.sv
// Serial-bus address decoder: shifts in an LSB-first address, matches it against
// per-target base/mask windows and holds a one-hot select for one data frame.
module addr_decoder_param #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_TARGETS = 3,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_BASE = {16'h8000, 16'h4000, 16'h0000},
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_MASK = {16'hF000, 16'hC000, 16'hF800},
    parameter int SPLIT_TARGET = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bus_data_in,
    input  logic                   bus_data_in_valid,
    input  logic                   bus_mode,
    input  logic                   split,
    output logic [NUM_TARGETS-1:0] target_valid,
    output logic [((NUM_TARGETS > 2) ? $clog2(NUM_TARGETS) : 1)-1:0] sel,
    output logic                   decode_err,
    output logic                   txn_done
);

    localparam int SW  = (NUM_TARGETS > 2) ? $clog2(NUM_TARGETS) : 1;
    localparam int ACW = $clog2(ADDR_WIDTH + 1);
    localparam int DCW = $clog2(DATA_WIDTH + 1);
    localparam logic [ACW-1:0] ADDR_LAST = ACW'(ADDR_WIDTH - 1);
    localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_ADDR,
        ST_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   shift_q, shift_d;
    logic [ACW-1:0]          acnt_q, acnt_d;
    logic [DCW-1:0]          dcnt_q, dcnt_d;
    logic [NUM_TARGETS-1:0]  tv_q, tv_d;
    logic [SW-1:0]           sel_q, sel_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic [ADDR_WIDTH-1:0]   full_addr;
    logic                    hit;
    logic [SW-1:0]           hit_idx;
    logic [NUM_TARGETS-1:0]  hit_vec;
    logic [NUM_TARGETS-1:0]  split_vec;

    // Address as it will look once the incoming bit is shifted in.
    assign full_addr = {bus_data_in, shift_q[ADDR_WIDTH-1:1]};

    // Window match; scanning upward with a found flag gives lowest index priority.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_vec = '0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            if (!hit &&
                ((full_addr & TARGET_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 TARGET_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit        = 1'b1;
                hit_idx    = SW'(i);
                hit_vec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            tv_q    <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
            tv_q    <= tv_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acnt_d  = acnt_q;
        dcnt_d  = dcnt_q;
        tv_d    = tv_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_ADDR: begin
                if (!bus_mode) begin
                    if (bus_data_in_valid) begin
                        shift_d = full_addr;
                        if (acnt_q == ADDR_LAST) begin
                            acnt_d = '0;
                            if (hit) begin
                                tv_d    = hit_vec;
                                sel_d   = hit_idx;
                                dcnt_d  = '0;
                                state_d = ST_HOLD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            acnt_d = acnt_q + ACW'(1);
                        end
                    end
                end else if (acnt_q != '0) begin
                    // Data phase during a partial address: abort the frame silently.
                    acnt_d  = '0;
                    shift_d = '0;
                end
            end
            ST_HOLD: begin
                if (bus_mode) begin
                    if (bus_data_in_valid) begin
                        if (dcnt_q == DATA_LAST) begin
                            tv_d    = '0;
                            sel_d   = '0;
                            dcnt_d  = '0;
                            done_d  = 1'b1;
                            state_d = ST_ADDR;
                        end else begin
                            dcnt_d = dcnt_q + DCW'(1);
                        end
                    end
                end else begin
                    dcnt_d = '0;
                end
            end
            default: state_d = ST_ADDR;
        endcase
    end

    always_comb begin
        split_vec               = '0;
        split_vec[SPLIT_TARGET] = 1'b1;
        if (split) begin
            target_valid = (state_q == ST_HOLD) ? split_vec : '0;
            sel          = SW'(SPLIT_TARGET);
        end else begin
            target_valid = tv_q;
            sel          = sel_q;
        end
    end

    assign decode_err = err_q;
    assign txn_done   = done_q;

endmodule
